// File: rtl/clock_counter_master.sv
// Avalon-MM master that turns start/stop event pulses into corrected clock-counter measurements.
// Define CLOCK_COUNTER_MASTER_STATS_EN to build min/max/count statistics over accepted results.
module clock_counter_master #(
    parameter int READ_LATENCY = 1,
    parameter int OVERHEAD     = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        result_valid,
    output logic [31:0] result_data,
    input  logic        result_ready,
    output logic [7:0]  missed_starts,
    output logic        busy,
    input  logic        stats_clear,
    output logic [31:0] stat_min,
    output logic [31:0] stat_max,
    output logic [15:0] stat_count
);

    typedef enum logic [2:0] {
        CLEAR, ARMED, RUN_CMD, RUNNING, STOP_CMD, READ, WAIT_DATA, PUSH
    } state_t;

    localparam logic [31:0] OVERHEAD_W = 32'(OVERHEAD);
    localparam logic [2:0]  LAT_LAST   = 3'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  missed_q, missed_d;
    logic        busy_q, busy_d;
    logic        stop_pending_q, stop_pending_d;
    logic [2:0]  lat_q, lat_d;

    logic        accepted;
    logic [31:0] corrected;

    assign accepted  = (write_q | read_q) & ~avm_waitrequest;
    assign corrected = (avm_readdata >= OVERHEAD_W) ? (avm_readdata - OVERHEAD_W) : 32'd0;

    // Bus strobes come straight from the next state, so they stay put while the slave stalls.
    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        lat_d          = lat_q;
        data_d         = data_q;
        missed_d       = missed_q;

        case (state_q)
            CLEAR:     if (accepted) state_d = ARMED;
            ARMED:     if (start) state_d = RUN_CMD;
            RUN_CMD: begin
                if (stop) stop_pending_d = 1'b1;
                // A stop on the accepting edge itself must not slip past into RUNNING.
                if (accepted) state_d = (stop_pending_q || stop) ? STOP_CMD : RUNNING;
            end
            RUNNING:   if (stop) state_d = STOP_CMD;
            STOP_CMD:  if (accepted) state_d = READ;
            READ: begin
                if (accepted) begin
                    state_d = WAIT_DATA;
                    lat_d   = 3'd0;
                end
            end
            WAIT_DATA: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = corrected;
                    state_d = PUSH;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            PUSH:      if (result_ready) state_d = CLEAR;
            default:   state_d = CLEAR;
        endcase

        if (state_d == STOP_CMD && state_q != STOP_CMD) stop_pending_d = 1'b0;
        if (start && state_q != ARMED && missed_q != 8'hFF) missed_d = missed_q + 8'd1;
    end

    always_comb begin
        write_d = (state_d == CLEAR) || (state_d == RUN_CMD) || (state_d == STOP_CMD);
        wdata_d = ((state_d == RUN_CMD) || (state_d == STOP_CMD)) ? 32'd1 : 32'd0;
        read_d  = (state_d == READ);
        valid_d = (state_d == PUSH);
        busy_d  = (state_d != ARMED);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= CLEAR;
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            wdata_q        <= 32'd0;
            valid_q        <= 1'b0;
            data_q         <= 32'd0;
            missed_q       <= 8'd0;
            busy_q         <= 1'b1;
            stop_pending_q <= 1'b0;
            lat_q          <= 3'd0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            read_q         <= read_d;
            wdata_q        <= wdata_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
            missed_q       <= missed_d;
            busy_q         <= busy_d;
            stop_pending_q <= stop_pending_d;
            lat_q          <= lat_d;
        end
    end

    assign avm_write     = write_q;
    assign avm_read      = read_q;
    assign avm_writedata = wdata_q;
    assign result_valid  = valid_q;
    assign result_data   = data_q;
    assign missed_starts = missed_q;
    assign busy          = busy_q;

`ifdef CLOCK_COUNTER_MASTER_STATS_EN
    logic [31:0] stat_min_q, stat_max_q;
    logic [15:0] stat_count_q;
    logic        handshake;

    assign handshake = valid_q & result_ready;

    // An empty count marks the next result as the one that seeds both min and max.
    always_ff @(posedge clock) begin
        if (!reset_n || stats_clear) begin
            stat_min_q   <= 32'd0;
            stat_max_q   <= 32'd0;
            stat_count_q <= 16'd0;
        end else if (handshake) begin
            if (stat_count_q == 16'd0) begin
                stat_min_q <= data_q;
                stat_max_q <= data_q;
            end else begin
                if (data_q < stat_min_q) stat_min_q <= data_q;
                if (data_q > stat_max_q) stat_max_q <= data_q;
            end
            if (stat_count_q != 16'hFFFF) stat_count_q <= stat_count_q + 16'd1;
        end
    end

    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_count = stat_count_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = stats_clear;
    assign stat_min   = 32'd0;
    assign stat_max   = 32'd0;
    assign stat_count = 16'd0;
`endif

endmodule
